// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: registered output, full throughput, flush and halt control.
// Define PIPE_SKID_STAGE_STATS_EN to build the saturating backpressure (stall) counter.
module pipe_skid_stage #(
   parameter int                DATA_W      = 64,
   parameter logic [DATA_W-1:0] FLUSH_VALUE = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              halt_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic [15:0]       stall_cnt_o
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] main_p0;
   logic [DATA_W-1:0] skid_p0;
   logic              in_fire;
   logic              out_fire;
   logic              do_flush;
   logic              ld_main;
   logic              ld_skid;
   logic              mv_skid;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;
   assign do_flush = flush_i & ~halt_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= EMPTY;
      else       state <= state_nxt;
   end

   // Halt freezes everything; flush overrides any same-cycle transfer.
   always_comb begin
      state_nxt = state;
      ld_main   = 1'b0;
      ld_skid   = 1'b0;
      mv_skid   = 1'b0;
      if (!halt_i) begin
         if (flush_i) begin
            state_nxt = EMPTY;
         end else begin
            case (state)
               EMPTY: begin
                  if (in_fire) begin
                     ld_main   = 1'b1;
                     state_nxt = ONE;
                  end
               end
               ONE: begin
                  if (in_fire && out_fire) begin
                     ld_main = 1'b1;
                  end else if (in_fire) begin
                     ld_skid   = 1'b1;
                     state_nxt = FULL;
                  end else if (out_fire) begin
                     state_nxt = EMPTY;
                  end
               end
               FULL: begin
                  if (out_fire) begin
                     mv_skid   = 1'b1;
                     state_nxt = ONE;
                  end
               end
               default: state_nxt = EMPTY;
            endcase
         end
      end
   end

   always_comb begin
      in_ready_o  = (state != FULL)  & ~halt_i;
      out_valid_o = (state != EMPTY) & ~halt_i;
   end

   // ---- payload registers (p0): main feeds the output directly ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_p0 <= FLUSH_VALUE;
         skid_p0 <= FLUSH_VALUE;
      end else if (do_flush) begin
         main_p0 <= FLUSH_VALUE;
         skid_p0 <= FLUSH_VALUE;
      end else begin
         if (ld_main)      main_p0 <= in_data_i;
         else if (mv_skid) main_p0 <= skid_p0;
         if (ld_skid)      skid_p0 <= in_data_i;
      end
   end

   assign out_data_o = main_p0;

`ifdef PIPE_SKID_STAGE_STATS_EN
   logic [15:0] stall_cnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                           stall_cnt <= 16'd0;
      else if (do_flush)                   stall_cnt <= 16'd0;
      else if (out_valid_o && !out_ready_i) stall_cnt <= sat_inc(stall_cnt);
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: directed scenarios plus randomized traffic
// against a two-deep FIFO reference model.
module tb_pipe_skid_stage;

   localparam int          DW    = 64;
   localparam logic [DW-1:0] FLUSH = '0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          halt = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic [15:0]   stall_cnt;

   int checks = 0;
   int passes = 0;

   logic [DW-1:0] exp_q[$];
   int            occ = 0;
   logic [15:0]   exp_stall = 16'd0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(DW), .FLUSH_VALUE(FLUSH)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .halt_i(halt),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
      .stall_cnt_o(stall_cnt));

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: the stage behaves as a FIFO holding at most two entries.
   initial forever begin
      bit fin, fout;
      @(posedge clk or posedge rst);
      if (rst) begin
         occ = 0; exp_q.delete(); exp_stall = 16'd0;
      end else if (!halt) begin
         if (flush) begin
            occ = 0; exp_q.delete(); exp_stall = 16'd0;
         end else begin
            fin  = in_valid && occ < 2;
            fout = out_ready && occ > 0;
            if (occ > 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (fin) exp_q.push_back(in_data);
            occ = occ + int'(fin) - int'(fout);
         end
      end
   end

   // Monitor: handshake, ordered payload delivery and stall count.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("in_ready", DW'(in_ready), DW'(!halt && occ < 2));
         check("out_valid", DW'(out_valid), DW'(!halt && occ > 0));
         if (out_valid && out_ready && !(flush && !halt)) begin
            if (exp_q.size() == 0) check("unexpected_out", out_data, ~out_data);
            else check("out_data", out_data, exp_q.pop_front());
         end
`ifdef PIPE_SKID_STAGE_STATS_EN
         check("stall_cnt", DW'(stall_cnt), DW'(exp_stall));
`else
         check("stall_cnt_off", DW'(stall_cnt), '0);
`endif
      end
   end

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rdy,
                      input logic fl, input logic hl);
      in_valid = v; in_data = d; out_ready = rdy; flush = fl; halt = hl;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      in_valid = 0; out_ready = 0; flush = 0; halt = 0; in_data = '0;
      rst = 1'b1;
      #1;
      check("rst_out_valid", DW'(out_valid), '0);
      check("rst_in_ready", DW'(in_ready), DW'(1));
      check("rst_out_data", out_data, FLUSH);
      check("rst_stall", DW'(stall_cnt), '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Streaming at full rate
      cyc(1, 64'd1, 1, 0, 0);
      check("stream_first_valid", DW'(out_valid), DW'(1));
      check("stream_first_data", out_data, 64'd1);
      cyc(1, 64'd2, 1, 0, 0);
      check("stream_second_data", out_data, 64'd2);
      cyc(1, 64'd3, 1, 0, 0);
      cyc(1, 64'd4, 1, 0, 0);
      check("stream_fourth_data", out_data, 64'd4);
      cyc(0, 64'd0, 1, 0, 0);

      // Backpressure to FULL, then drain
      do_reset();
      cyc(1, 64'hA, 0, 0, 0);
      cyc(1, 64'hB, 0, 0, 0);
      in_valid = 0;
      #1;
      check("bp_full_ready", DW'(in_ready), '0);
      check("bp_main_data", out_data, 64'hA);
      cyc(0, 64'd0, 1, 0, 0);
      check("bp_second_data", out_data, 64'hB);
      cyc(0, 64'd0, 1, 0, 0);
      check("bp_drained", DW'(out_valid), '0);

      // Flush while FULL with a same-cycle input
      cyc(1, 64'h11, 0, 0, 0);
      cyc(1, 64'h22, 0, 0, 0);
      cyc(1, 64'hDEAD, 1, 1, 0);
      in_valid = 0; flush = 0;
      #1;
      check("flush_valid", DW'(out_valid), '0);
      check("flush_data", out_data, FLUSH);
      check("flush_ready", DW'(in_ready), DW'(1));
      cyc(0, 64'd0, 1, 0, 0);
      cyc(0, 64'd0, 1, 0, 0);

      // Halt has priority over flush
      cyc(1, 64'h55, 0, 0, 0);
      cyc(0, 64'd0, 0, 1, 1);
      check("halt_valid", DW'(out_valid), '0);
      check("halt_ready", DW'(in_ready), '0);
      cyc(0, 64'd0, 0, 1, 1);
      cyc(0, 64'd0, 0, 0, 0);
      check("post_halt_data", out_data, 64'h55);
      check("post_halt_valid", DW'(out_valid), DW'(1));

      // Stall counting: five backpressured cycles, then flush
      do_reset();
      cyc(1, 64'h77, 0, 0, 0);
      repeat (5) cyc(0, 64'd0, 0, 0, 0);
`ifdef PIPE_SKID_STAGE_STATS_EN
      check("stall_five", DW'(stall_cnt), DW'(5));
`else
      check("stall_five_off", DW'(stall_cnt), '0);
`endif
      cyc(0, 64'd0, 0, 1, 0);
      check("stall_cleared", DW'(stall_cnt), '0);

      // Asynchronous reset between edges while FULL
      cyc(1, 64'h33, 0, 0, 0);
      cyc(1, 64'h44, 0, 0, 0);
      in_valid = 0;
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", DW'(out_valid), '0);
      check("async_rst_data", out_data, FLUSH);
      check("async_rst_stall", DW'(stall_cnt), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1, 64'h66, 1, 0, 0);
      check("post_rst_first", out_data, 64'h66);
      cyc(0, 64'd0, 1, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
             $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
      end

      // Drain and confirm nothing is left outstanding
      repeat (4) cyc(0, 64'd0, 1, 0, 0);
      check("drain_empty", DW'(exp_q.size()), '0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
